ccff_chain_loader: RTL and testbench
====================================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 40: total number of configuration flip-flops in the downstream ccff chain.
REQ-002 SHALL have parameter WORD_W, default 32: width of one bitstream word.
REQ-003 SHALL have port prog_clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port prog_reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: a one-cycle pulse that begins a chain load.
REQ-006 SHALL have port abort, input, 1: terminates a load in progress.
REQ-007 SHALL have port cfg_valid, input, 1: the bitstream word is valid.
REQ-008 SHALL have port cfg_data, input, WORD_W: the bitstream word; bit 0 is shifted first.
REQ-009 SHALL have port cfg_ready, output, 1: the loader accepts a word.
REQ-010 SHALL have port ccff_head, output, 1: serial bit driven into the head of the fabric chain.
REQ-011 SHALL have port ccff_shift_en, output, 1: qualifies prog_clk to the chain through an external clock gate; the chain shifts one bit on each edge where it is 1.
REQ-012 SHALL have port ccff_tail, input, 1: serial bit returned from the chain tail.
REQ-013 SHALL have port busy, output, 1: a load is in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse on successful completion.
REQ-015 SHALL have port aborted, output, 1: sticky flag set by abort and cleared by the next start.
REQ-016 SHALL have port tail_parity, output, 1: XOR of all tail bits clocked out during the last load.

Function
REQ-017 SHALL implement the FSM states IDLE, WAIT_WORD, SHIFT and DONE.
REQ-018 SHALL go IDLE->WAIT_WORD on start; start SHALL be ignored outside IDLE.
REQ-019 SHALL clear the bit counter, tail_parity and aborted on the start that is accepted.
REQ-020 SHALL assert cfg_ready only in WAIT_WORD; a word SHALL be accepted on cfg_valid&&cfg_ready and the FSM SHALL go to SHIFT on the next edge.
REQ-021 SHALL, in SHIFT, present one bit per cycle on ccff_head with ccff_shift_en=1, in order from bit 0 upward, from a registered word buffer.
REQ-022 SHALL keep ccff_head and ccff_shift_en as registered outputs; ccff_shift_en SHALL be 0 in every state other than SHIFT.
REQ-023 SHALL shift min(WORD_W, CHAIN_LEN - bits_sent) bits per word; the unused high bits of the final word SHALL be discarded.
REQ-024 SHALL return from SHIFT to WAIT_WORD after the word is exhausted if bits_sent < CHAIN_LEN, and to DONE otherwise.
REQ-025 SHALL not insert a bubble cycle between the bits of one word; there SHALL be at least one cycle with ccff_shift_en=0 between words.
REQ-026 SHALL update tail_parity ^= ccff_tail on every edge where the registered ccff_shift_en is 1, so that exactly CHAIN_LEN samples are taken per load.
REQ-027 SHALL assert done for exactly one cycle in DONE and then return to IDLE.
REQ-028 SHALL assert busy in WAIT_WORD and SHIFT only.
REQ-029 SHALL, on abort in WAIT_WORD or SHIFT, go to IDLE on the next edge, deassert ccff_shift_en, set aborted=1 and not pulse done.
REQ-030 SHALL ignore abort in IDLE and in DONE.
REQ-031 SHALL give abort priority when abort and a word handshake occur in the same cycle; the word SHALL be dropped.
REQ-032 SHALL size the bit counter as $clog2(CHAIN_LEN+1) and the in-word index as $clog2(WORD_W+1); the counter SHALL never exceed CHAIN_LEN.

Reset
REQ-033 SHALL, on prog_reset, put the FSM in IDLE and drive ccff_head=0, ccff_shift_en=0, cfg_ready=0, busy=0, done=0, aborted=0 and tail_parity=0.
REQ-034 SHALL let prog_reset in the middle of a load override every input; no done pulse SHALL follow, and the load SHALL be restarted only by a new start.

Structure
REQ-035 SHALL place the FSM state enumeration and the default CHAIN_LEN and WORD_W constants in the shared fabric configuration package.
REQ-036 SHALL contain a single sub-module, ccff_word_serializer, which is a WORD_W-bit load/shift register with a bit-index counter.

Verification
REQ-037 SHALL cover nominal load: CHAIN_LEN=40, WORD_W=32, words 0xA5A5A5A5 and 0x0000003C -> exactly 40 shift_en cycles, head sequence matches LSB-first order, one done pulse.
REQ-038 SHALL cover the partial last word: second word 0xFFFFFF3C -> only the low 8 bits (0x3C) are shifted and bits_sent stops at 40.
REQ-039 SHALL cover readback: the chain is modelled as a 40-bit shift register preloaded with 0x1 -> tail_parity=1; a second load of all zeros -> tail_parity equals the parity of the first load's data.
REQ-040 SHALL cover abort after 10 bits of the first word -> IDLE on the next cycle, aborted=1, no done, shift_en=0; a new start clears aborted.
REQ-041 SHALL cover back-pressure: cfg_valid withheld for 5 cycles in WAIT_WORD -> cfg_ready held at 1, shift_en held at 0, no bits lost.
REQ-042 SHALL cover prog_reset asserted during SHIFT -> all outputs at reset values on the next cycle; start is ignored while busy.

Source files
------------

// File: rtl/ccff_chain_loader_pkg.sv
// Shared fabric configuration definitions for the ccff chain loader.
package ccff_chain_loader_pkg;

    localparam int unsigned DEFAULT_CHAIN_LEN = 40;
    localparam int unsigned DEFAULT_WORD_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        SHIFT,
        DONE
    } loader_state_t;

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer that hands out one bit per shift, LSB first, and counts bits issued.
module ccff_word_serializer
    import ccff_chain_loader_pkg::*;
#(
    parameter int unsigned WORD_W = DEFAULT_WORD_W,
    parameter int unsigned IDX_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    output logic              head_next,
    output logic [IDX_W-1:0]  idx
);

    logic [WORD_W-1:0] word;

    // Bit 0 is issued on the load edge itself, so the buffer keeps only the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
            idx  <= '0;
        end else if (load) begin
            word <= data >> 1;
            idx  <= IDX_W'(1);
        end else if (shift) begin
            word <= word >> 1;
            idx  <= idx + IDX_W'(1);
        end
    end

    assign head_next = load ? data[0] : word[0];

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words serially into a configuration flip-flop chain and
// folds the bits returned from the chain tail into a parity flag.
module ccff_chain_loader
    import ccff_chain_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int unsigned WORD_W    = DEFAULT_WORD_W
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              tail_parity
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned IDX_W = $clog2(WORD_W + 1);

    loader_state_t    state;
    loader_state_t    next_state;
    logic [CNT_W-1:0] bits_sent;
    logic [IDX_W-1:0] word_len;
    logic [IDX_W-1:0] next_len;
    logic [IDX_W-1:0] idx;
    logic [31:0]      remaining;
    logic             head_next;
    logic             load;
    logic             shift;
    logic             emit;
    logic             more;
    logic             start_ok;
    logic             abort_ok;

    ccff_word_serializer #(
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) serializer (
        .clk       (prog_clk),
        .reset     (prog_reset),
        .load      (load),
        .shift     (shift),
        .data      (cfg_data),
        .head_next (head_next),
        .idx       (idx)
    );

    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        start_ok   = 1'b0;
        abort_ok   = 1'b0;
        remaining  = 32'(CHAIN_LEN) - 32'(bits_sent);
        next_len   = (remaining > 32'(WORD_W)) ? IDX_W'(WORD_W) : IDX_W'(remaining);
        more       = idx < word_len;
        case (state)
            IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    next_state = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                if (abort) begin
                    abort_ok   = 1'b1;
                    next_state = IDLE;
                end else if (cfg_valid) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    abort_ok   = 1'b1;
                    next_state = IDLE;
                end else if (more) begin
                    shift = 1'b1;
                end else if (32'(bits_sent) < 32'(CHAIN_LEN)) begin
                    next_state = WAIT_WORD;
                end else begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        emit = load | shift;
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state         <= IDLE;
            cfg_ready     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            aborted       <= 1'b0;
            tail_parity   <= 1'b0;
            bits_sent     <= '0;
            word_len      <= '0;
        end else begin
            state         <= next_state;
            cfg_ready     <= (next_state == WAIT_WORD);
            busy          <= (next_state == WAIT_WORD) || (next_state == SHIFT);
            done          <= (next_state == DONE);
            ccff_shift_en <= emit;
            ccff_head     <= emit & head_next;
            if (load) begin
                word_len <= next_len;
            end
            if (start_ok) begin
                bits_sent   <= '0;
                tail_parity <= 1'b0;
                aborted     <= 1'b0;
            end else begin
                if (emit) begin
                    bits_sent <= bits_sent + CNT_W'(1);
                end
                if (ccff_shift_en) begin
                    tail_parity <= tail_parity ^ ccff_tail;
                end
                if (abort_ok) begin
                    aborted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized and directed bench for ccff_chain_loader with a behavioural fabric chain.
module tb_ccff_chain_loader;

    localparam int unsigned CHAIN_LEN = 40;
    localparam int unsigned WORD_W    = 32;

    logic                 prog_clk = 1'b0;
    logic                 prog_reset;
    logic                 start;
    logic                 abort;
    logic                 cfg_valid;
    logic [WORD_W-1:0]    cfg_data;
    logic                 cfg_ready;
    logic                 ccff_head;
    logic                 ccff_shift_en;
    logic                 ccff_tail;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic                 tail_parity;

    logic [CHAIN_LEN-1:0] chain;
    logic [CHAIN_LEN-1:0] snap;
    logic [CHAIN_LEN-1:0] preload_val;
    logic                 preload_req;
    logic                 mon_clr;
    logic [63:0]          got;
    int                   shifts;
    int                   dones;
    int                   vectors     = 0;
    int                   miscompares = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .abort         (abort),
        .cfg_valid     (cfg_valid),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .tail_parity   (tail_parity)
    );

    // Fabric chain: head enters at bit 0, tail leaves from the top bit.
    assign ccff_tail = chain[CHAIN_LEN-1];
    always @(posedge prog_clk) begin
        if (preload_req) chain <= preload_val;
        else if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end

    always @(negedge prog_clk) begin
        if (mon_clr) begin
            shifts <= 0;
            got    <= '0;
            dones  <= 0;
        end else begin
            if (ccff_shift_en) begin
                if (shifts < 64) got[shifts] <= ccff_head;
                shifts <= shifts + 1;
            end
            if (done) dones <= dones + 1;
        end
    end

    task automatic tick();
        @(negedge prog_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_bits(input logic [31:0] w0, input logic [31:0] w1);
        logic [63:0] v;
        v = {w1, w0};
        return v & ((64'd1 << CHAIN_LEN) - 64'd1);
    endfunction

    // Parity of the first n bits to leave the chain, tail end first.
    function automatic logic exp_par(input logic [CHAIN_LEN-1:0] c, input int n);
        logic p = 1'b0;
        for (int i = 0; i < n; i++) p ^= c[CHAIN_LEN-1-i];
        return p;
    endfunction

    task automatic preload(input logic [CHAIN_LEN-1:0] v);
        preload_val = v;
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
    endtask

    task automatic pulse_start();
        snap    = chain;
        mon_clr = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit check_gap);
        int n = 0;
        while (!cfg_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cfg_ready) begin
            chk("ready_timeout", 64'(cfg_ready), 64'd1);
            return;
        end
        for (int g = 0; g < gap; g++) begin
            tick();
            if (check_gap) begin
                chk("bp_ready", 64'(cfg_ready), 64'd1);
                chk("bp_shift_en", 64'(ccff_shift_en), 64'd0);
            end
        end
        cfg_valid = 1'b1;
        cfg_data  = w;
        tick();
        cfg_valid = 1'b0;
        cfg_data  = $urandom;
        chk("shift_busy", 64'({busy, cfg_ready, ccff_shift_en}), 64'b101);
    endtask

    task automatic wait_done();
        int n = 0;
        while (dones == 0 && n < 200) begin
            tick();
            n++;
        end
        if (dones == 0) chk("done_timeout", 64'(dones), 64'd1);
        tick();
        tick();
    endtask

    task automatic full_load(input logic [31:0] w0, input logic [31:0] w1,
                             input int gap, input bit check_gap);
        pulse_start();
        send_word(w0, gap, check_gap);
        send_word(w1, 0, 1'b0);
        wait_done();
        chk("shift_count", 64'(shifts), 64'(CHAIN_LEN));
        chk("head_bits", got, exp_bits(w0, w1));
        chk("done_pulses", 64'(dones), 64'd1);
        chk("tail_parity", 64'(tail_parity), 64'(exp_par(snap, CHAIN_LEN)));
        chk("idle_after", 64'({busy, cfg_ready, ccff_shift_en, aborted}), 64'd0);
    endtask

    initial begin
        logic [63:0] prev;
        logic [31:0] w;
        int n;

        prog_reset  = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_data    = '0;
        preload_req = 1'b0;
        preload_val = '0;
        mon_clr     = 1'b1;
        tick();
        tick();
        mon_clr = 1'b0;
        chk("reset_outputs",
            64'({cfg_ready, ccff_head, ccff_shift_en, busy, done, aborted, tail_parity}), 64'd0);
        prog_reset = 1'b0;
        tick();

        // Nominal load with a chain preloaded to 0x1, then a truncated last word.
        preload(40'h1);
        full_load(32'hA5A5A5A5, 32'h0000003C, 0, 1'b0);
        chk("preload_parity", 64'(tail_parity), 64'd1);
        full_load(32'hA5A5A5A5, 32'hFFFFFF3C, 0, 1'b0);
        prev = exp_bits(32'hA5A5A5A5, 32'hFFFFFF3C);
        full_load(32'h0, 32'h0, 0, 1'b0);
        chk("readback_parity", 64'(tail_parity), 64'(^prev));

        // Back-pressure on the first word.
        full_load($urandom, $urandom, 5, 1'b1);

        // Abort after ten bits of the first word.
        pulse_start();
        w = $urandom;
        send_word(w, 0, 1'b0);
        n = 0;
        while (shifts < 10 && n < 100) begin
            tick();
            n++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 64'({busy, cfg_ready, ccff_shift_en}), 64'd0);
        chk("abort_flag", 64'(aborted), 64'd1);
        tick();
        tick();
        chk("abort_shifts", 64'(shifts), 64'd10);
        chk("abort_bits", got, 64'(w[9:0]));
        chk("abort_no_done", 64'(dones), 64'd0);
        chk("abort_parity", 64'(tail_parity), 64'(exp_par(snap, 10)));
        pulse_start();
        chk("abort_cleared", 64'(aborted), 64'd0);

        // Abort wins over a same-cycle word handshake.
        cfg_valid = 1'b1;
        cfg_data  = $urandom;
        abort     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        abort     = 1'b0;
        tick();
        chk("abort_hs_idle", 64'({busy, ccff_shift_en, aborted}), 64'b001);
        chk("abort_hs_shifts", 64'(shifts), 64'd0);

        for (int i = 0; i < 6; i++) begin
            full_load($urandom, $urandom, int'($urandom_range(0, 3)), 1'b0);
        end

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ignored", 64'({aborted, busy}), 64'd0);

        // Start while shifting is ignored; reset mid-load overrides everything.
        pulse_start();
        send_word($urandom, 0, 1'b0);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored", 64'({busy, ccff_shift_en, aborted}), 64'b110);
        chk("start_ignored_shifts", 64'(shifts), 64'd4);
        start      = 1'b1;
        prog_reset = 1'b1;
        tick();
        start      = 1'b0;
        prog_reset = 1'b0;
        chk("midload_reset",
            64'({cfg_ready, ccff_head, ccff_shift_en, busy, done, aborted, tail_parity}), 64'd0);
        repeat (4) tick();
        chk("reset_no_restart", 64'({busy, ccff_shift_en, cfg_ready}), 64'd0);
        chk("reset_no_done", 64'(dones), 64'd0);

        full_load($urandom, $urandom, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
